// File: rtl/score_rom_if.sv
// Score ROM bus: sequencer drives the address, sync ROM returns the word.
// Read data lags the address by one clock.
interface score_rom_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/score_sequencer.sv
// Music box playback controller: walks the score ROM, times notes
// and articulation gaps, handles play/pause and song selection.
module score_sequencer #(
  parameter int UNIT_TICKS = 3125000,
  parameter int GAP_TICKS  = 500000,
  parameter int NUM_SONGS  = 4,
  parameter int ADDR_W     = 16,
  localparam int SW = (NUM_SONGS > 1) ?
                      $clog2(NUM_SONGS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        btn_play,
  input  logic                        btn_next,
  input  logic                        btn_prev,
  input  logic                        loop_en,
  input  logic [NUM_SONGS*ADDR_W-1:0] song_base,
  score_rom_if.master                 rom,
  output logic [15:0]                 signal,
  output logic [2:0]                  band,
  output logic                        playing,
  output logic                        paused,
  output logic [SW-1:0]               song_idx
);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, HOLD, GAP, PAUSED
  } state_t;

  state_t            state_q, state_d;
  state_t            saved_q, saved_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       tone_q, tone_d;
  logic [2:0]        band_q, band_d;
  logic [SW-1:0]     idx_q, idx_d;

  logic [SW-1:0]     idx_step;
  logic [ADDR_W-1:0] base_cur, base_step;
  logic [3:0]        note;
  logic [4:0]        len;
  logic [31:0]       note_cnt;
  logic              active, song_chg;

  assign note = rom.rom_data[11:8];
  assign len  = rom.rom_data[4:0];
  assign note_cnt = 32'(len) * 32'(UNIT_TICKS)
                  - 32'(GAP_TICKS);

  assign active = state_q inside
                  {FETCH, LOAD, HOLD, GAP};
  assign song_chg = btn_next ^ btn_prev;

  always_comb begin
    idx_step = idx_q;
    if (btn_next) begin
      idx_step = (idx_q == SW'(NUM_SONGS - 1)) ?
                 '0 : idx_q + 1'b1;
    end else if (btn_prev) begin
      idx_step = (idx_q == '0) ?
                 SW'(NUM_SONGS - 1) : idx_q - 1'b1;
    end
  end

  assign base_cur  =
    song_base[int'(idx_q) * ADDR_W +: ADDR_W];
  assign base_step =
    song_base[int'(idx_step) * ADDR_W +: ADDR_W];

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    tone_d  = tone_q;
    band_d  = band_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (btn_play) begin
          addr_d  = base_cur;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        if (len == 5'd0) begin
          if (loop_en) begin
            addr_d  = base_cur;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tone_d  = (note == 4'd0) ? '0 :
                    16'd1 << note;
          band_d  = rom.rom_data[7:5];
          cnt_d   = note_cnt;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == 32'd1) begin
          if (GAP_TICKS == 0) begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end else begin
            cnt_d   = 32'(GAP_TICKS);
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      GAP: begin
        if (cnt_q == 32'd1) begin
          addr_d  = addr_q + 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      PAUSED: begin
        if (btn_play) state_d = saved_q;
      end
      default: state_d = IDLE;
    endcase

    // A pause during HOLD/GAP lets the current cycle count,
    // so the resumed note sounds for exactly what is left.
    if (btn_play && state_q inside {FETCH, LOAD}) begin
      saved_d = FETCH;
      state_d = PAUSED;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      tone_d  = tone_q;
      band_d  = band_q;
    end else if (btn_play &&
                 state_q inside {HOLD, GAP}) begin
      saved_d = state_d;
      state_d = PAUSED;
    end

    if (song_chg) begin
      idx_d   = idx_step;
      addr_d  = base_step;
      cnt_d   = cnt_q;
      tone_d  = tone_q;
      band_d  = band_q;
      state_d = active ? FETCH : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      saved_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= song_base[ADDR_W-1:0];
      tone_q  <= '0;
      band_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      tone_q  <= tone_d;
      band_q  <= band_d;
      idx_q   <= idx_d;
    end
  end

  assign rom.rom_addr = addr_q;
  assign signal   = (state_q == HOLD) ? tone_q : '0;
  assign band     = band_q;
  assign playing  = active;
  assign paused   = (state_q == PAUSED);
  assign song_idx = idx_q;
endmodule
